// File: rtl/demux_rr_sched.sv
// Round-robin burst scheduler for the 1-to-8 demux fabric.
// Holds one word and drives the demux select toward enabled channels.
module demux_rr_sched #(
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  input  logic [W-1:0] i_in_data,
  output logic         o_in_ready,
  input  logic [7:0]   i_en_mask,
  output logic [W-1:0] o_out_data,
  output logic [7:0]   o_out_valid,
  input  logic [7:0]   i_out_ready,
  output logic [2:0]   o_sel,
  output logic         o_busy
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(BURST - 1);

  state_t       r_state;
  state_t       w_state;
  logic [2:0]   r_sel;
  logic [2:0]   w_sel;
  logic [2:0]   r_last;
  logic [2:0]   w_last;
  logic [7:0]   r_cnt;
  logic [7:0]   w_cnt;
  logic [W-1:0] r_hold_data;
  logic         r_hold_full;

  logic         w_grant;
  logic         w_sel_en;
  logic         w_fire;
  logic         w_accept;
  logic [2:0]   w_nxt;

  assign w_grant    = (r_state == S_GRANT);
  assign w_sel_en   = i_en_mask[r_sel];
  // A transfer needs the channel enabled, so a disabled channel never eats a word.
  assign w_fire     = r_hold_full && w_grant && w_sel_en && i_out_ready[r_sel];
  assign o_in_ready = !r_hold_full || w_fire;
  assign w_accept   = i_in_valid && o_in_ready;

  assign o_out_data  = r_hold_data;
  assign o_out_valid = (r_hold_full && w_grant && w_sel_en) ?
                       (8'h01 << r_sel) : 8'h00;
  assign o_sel       = r_sel;
  assign o_busy      = w_grant;

  // First enabled channel after last, wrapping back to last itself.
  always_comb begin : search
    logic       found;
    logic [2:0] idx;
    w_nxt = r_last;
    found = 1'b0;
    idx   = r_last;
    for (int i = 1; i <= 8; i++) begin
      idx = r_last + 3'(i);
      if (!found && i_en_mask[idx]) begin
        w_nxt = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_sel   = r_sel;
    w_last  = r_last;
    w_cnt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (i_en_mask != 8'h00) begin
          w_state = S_GRANT;
          w_sel   = w_nxt;
          w_last  = w_nxt;
          w_cnt   = 8'h00;
        end
      end
      S_GRANT: begin
        if (i_en_mask == 8'h00) begin
          w_state = S_IDLE;
          w_cnt   = 8'h00;
        end else if ((w_fire && r_cnt == CNT_MAX) || !w_sel_en) begin
          w_sel  = w_nxt;
          w_last = w_nxt;
          w_cnt  = 8'h00;
        end else if (w_fire) begin
          w_cnt = r_cnt + 8'h01;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_sel   <= 3'd0;
      r_last  <= 3'd7;
      r_cnt   <= 8'h00;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_last  <= w_last;
      r_cnt   <= w_cnt;
    end
  end

  // Accept and fire together reload the register and keep it full.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_data <= i_in_data;
    end else if (w_fire) begin
      r_hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Directed bench for demux_rr_sched.
// Deliveries are logged as {channel, data} and compared to hand-built lists.
module tb_demux_rr_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [7:0] en_mask = 8'h00;
  logic [7:0] out_data;
  logic [7:0] out_valid;
  logic [7:0] out_ready = 8'h00;
  logic [2:0] sel;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [10:0] dq[$];
  int          dc[$];
  int          cyc = 0;
  logic [7:0]  seen = 8'h00;
  logic [10:0] exp_q[$];

  demux_rr_sched #(.W(8), .BURST(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in_valid (in_valid),
    .i_in_data  (in_data),
    .o_in_ready (in_ready),
    .i_en_mask  (en_mask),
    .o_out_data (out_data),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_sel      (sel),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      for (int k = 0; k < 8; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          dq.push_back({3'(k), out_data});
          dc.push_back(cyc);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      seen = seen | out_valid;
      if (out_valid != 8'h00) chk("onehot", out_valid, 8'h01 << sel);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d);
    logic rdy;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    n        = 0;
    rdy      = 1'b0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      seen = seen | out_valid;
      rdy  = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    en_mask   = 8'h00;
    out_ready = 8'h00;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 8'h00;
    dq.delete();
    dc.delete();
    exp_q.delete();
  endtask

  task automatic check_q(input string tag);
    chk({tag, "_count"}, dq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dq.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), dq[i], exp_q[i]);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 8'h00);
    chk("rst_sel", sel, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_data", out_data, 8'h00);
    @(posedge clk);
    #1;

    // 1: all channels, 16 words, bursts of 4
    dq.delete();
    dc.delete();
    en_mask   = 8'hFF;
    out_ready = 8'hFF;
    for (int i = 0; i < 16; i++) send(8'(i));
    tick(3);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back({3'(i / 4), 8'(i)});
    check_q("t1");
    if (dc.size() == 16) chk("t1_gap", dc[15] - dc[0], 32'd15);
    else chk("t1_gap_n", dc.size(), 32'd16);

    // 2: sparse mask 0x22
    do_reset();
    en_mask   = 8'h22;
    out_ready = 8'hFF;
    for (int i = 0; i < 12; i++) send(8'(i));
    tick(3);
    for (int i = 0; i < 12; i++)
      exp_q.push_back({((i / 4) == 1) ? 3'd5 : 3'd1, 8'(i)});
    check_q("t2");
    chk("t2_seen", seen, 8'h22);

    // 3: backpressure on ch0
    do_reset();
    en_mask = 8'h01;
    send(8'hA5);
    repeat (3) begin
      @(negedge clk);
      chk("t3_valid", out_valid, 8'h01);
      chk("t3_data", out_data, 8'hA5);
      chk("t3_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    out_ready = 8'h01;
    tick(3);
    exp_q.push_back({3'd0, 8'hA5});
    check_q("t3");
    chk("t3_empty", in_ready, 1'b1);

    // 4: disable ch2 mid-burst with a word pending
    do_reset();
    en_mask   = 8'h14;
    out_ready = 8'hFF;
    send(8'h11);
    tick(1);
    out_ready = 8'hFB;
    send(8'h3C);
    en_mask = 8'h10;
    tick(1);
    @(negedge clk);
    chk("t4_sel", sel, 3'd4);
    chk("t4_valid", out_valid, 8'h10);
    chk("t4_data", out_data, 8'h3C);
    @(posedge clk);
    #1;
    en_mask   = 8'h14;
    out_ready = 8'hFF;
    send(8'h41);
    send(8'h42);
    send(8'h43);
    send(8'h44);
    tick(3);
    exp_q.push_back({3'd2, 8'h11});
    exp_q.push_back({3'd4, 8'h3C});
    exp_q.push_back({3'd4, 8'h41});
    exp_q.push_back({3'd4, 8'h42});
    exp_q.push_back({3'd4, 8'h43});
    exp_q.push_back({3'd2, 8'h44});
    check_q("t4");

    // 5: mask to zero with a held word, then enable ch7
    do_reset();
    en_mask = 8'h01;
    send(8'h77);
    en_mask = 8'h00;
    tick(1);
    @(negedge clk);
    chk("t5_busy", busy, 1'b0);
    chk("t5_valid", out_valid, 8'h00);
    chk("t5_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    en_mask   = 8'h80;
    out_ready = 8'hFF;
    tick(1);
    @(negedge clk);
    chk("t5_sel", sel, 3'd7);
    chk("t5_valid7", out_valid, 8'h80);
    chk("t5_data", out_data, 8'h77);
    @(posedge clk);
    #1;
    tick(2);
    exp_q.push_back({3'd7, 8'h77});
    check_q("t5");

    // 6: reset while holding a word on ch5
    do_reset();
    en_mask = 8'h20;
    send(8'h99);
    @(negedge clk);
    chk("t6_sel5", sel, 3'd5);
    chk("t6_busy1", busy, 1'b1);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    en_mask   = 8'hFF;
    out_ready = 8'hFF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", out_valid, 8'h00);
    chk("t6_sel", sel, 3'd0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    send(8'hB1);
    tick(2);
    exp_q.push_back({3'd0, 8'hB1});
    check_q("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
